// File: rtl/menu_nav_if.sv
// Button/menu-cursor bundle shared by the menu navigation controller and its driver.
// master drives the debounced button levels and press pulses; slave returns cursor and event pulses.
interface menu_nav_if #(
  parameter int N_ITEMS = 8
);
  localparam int CW = $clog2(N_ITEMS);

  logic [3:0]    btn_state;
  logic [3:0]    btn_down;
  logic [CW-1:0] cursor;
  logic          cursor_chg;
  logic          sel_pulse;
  logic          back_pulse;

  modport master (
    output btn_state,
    output btn_down,
    input  cursor,
    input  cursor_chg,
    input  sel_pulse,
    input  back_pulse
  );

  modport slave (
    input  btn_state,
    input  btn_down,
    output cursor,
    output cursor_chg,
    output sel_pulse,
    output back_pulse
  );
endinterface

// File: rtl/menu_nav_ctrl.sv
// Menu cursor controller: up/down stepping with press-and-hold auto-repeat, plus select/back pulses.
// Define MENU_NAV_WRAP_EN to wrap the cursor at the list ends; otherwise it saturates.
module menu_nav_ctrl #(
  parameter int N_ITEMS    = 8,
  parameter int DELAY_CYC  = 12500000,
  parameter int REPEAT_CYC = 2500000
) (
  input  logic       clk,
  input  logic       resetn,
  menu_nav_if.slave  nav
);

  localparam int            CW       = $clog2(N_ITEMS);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_ITEMS - 1);
  localparam logic [31:0]   DLY_LAST = 32'(DELAY_CYC - 1);
  localparam logic [31:0]   RPT_LAST = 32'(REPEAT_CYC - 1);

  generate
    if (N_ITEMS < 2 || N_ITEMS > 256) begin : g_bad_items
      $error("menu_nav_ctrl: N_ITEMS out of range 2..256");
    end
    if (DELAY_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_timing
      $error("menu_nav_ctrl: DELAY_CYC and REPEAT_CYC must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_RPT = 2'd2
  } state_t;

  // One cursor move; the list ends either wrap or saturate depending on build.
  function automatic logic [CW-1:0] step_cursor(input logic [CW-1:0] cur,
                                                input logic          dn);
    logic [CW-1:0] res;
    res = cur;
    if (dn) begin
      if (cur == LAST_IDX) begin
`ifdef MENU_NAV_WRAP_EN
        res = '0;
`else
        res = cur;
`endif
      end else begin
        res = cur + 1'b1;
      end
    end else begin
      if (cur == '0) begin
`ifdef MENU_NAV_WRAP_EN
        res = LAST_IDX;
`else
        res = cur;
`endif
      end else begin
        res = cur - 1'b1;
      end
    end
    return res;
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          dir_q, dir_d;      // 1 = down, 0 = up
  logic          step_p0;
  logic          step_dn_p0;
  logic          hold_lost_p0;
  logic [CW-1:0] cursor_nxt_p0;

  logic [CW-1:0] cursor_p1;
  logic          chg_p1;
  logic          sel_p1;
  logic          back_p1;

  // Stage p0: decode presses/holds into a step request and next cursor.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    step_p0       = 1'b0;
    step_dn_p0    = dir_q;
    hold_lost_p0  = dir_q ? (!nav.btn_state[1] || nav.btn_state[0])
                          : (!nav.btn_state[0] || nav.btn_state[1]);
    case (state_q)
      IDLE: begin
        if (nav.btn_down[0] ^ nav.btn_down[1]) begin
          step_p0    = 1'b1;
          step_dn_p0 = nav.btn_down[1];
          dir_d      = nav.btn_down[1];
          cnt_d      = '0;
          state_d    = HOLD_DLY;
        end
      end
      HOLD_DLY: begin
        if (hold_lost_p0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == DLY_LAST) begin
          step_p0 = 1'b1;
          cnt_d   = '0;
          state_d = HOLD_RPT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLD_RPT: begin
        if (hold_lost_p0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == RPT_LAST) begin
          step_p0 = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    cursor_nxt_p0 = step_p0 ? step_cursor(cursor_p1, step_dn_p0) : cursor_p1;
  end

  // Stage p1: registered state, cursor and event pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      cursor_p1 <= '0;
      chg_p1    <= 1'b0;
      sel_p1    <= 1'b0;
      back_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      cursor_p1 <= cursor_nxt_p0;
      chg_p1    <= (cursor_nxt_p0 != cursor_p1);
      sel_p1    <= nav.btn_down[2] && !nav.btn_down[3];
      back_p1   <= nav.btn_down[3];
    end
  end

  assign nav.cursor     = cursor_p1;
  assign nav.cursor_chg = chg_p1;
  assign nav.sel_pulse  = sel_p1;
  assign nav.back_pulse = back_p1;

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Scoreboard bench for menu_nav_ctrl (N_ITEMS=5, DELAY_CYC=10, REPEAT_CYC=4).
// Expected cursor/pulse events are queued with their cycle when stimulus is driven.
module tb_menu_nav_ctrl;

  localparam int NI  = 5;
  localparam int DLY = 10;
  localparam int RPT = 4;
`ifdef MENU_NAV_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   exp_cur = 0;
  int   mon_c, mon_v, e;

  int q_chg_cyc[$];
  int q_chg_val[$];
  int q_sel[$];
  int q_back[$];

  menu_nav_if #(.N_ITEMS(NI)) nav ();

  menu_nav_ctrl #(
    .N_ITEMS   (NI),
    .DELAY_CYC (DLY),
    .REPEAT_CYC(RPT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .nav   (nav)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference cursor move; queues an event only when the value actually changes.
  task automatic step_exp(input int at, input bit dn);
    int nxt;
    if (dn) nxt = (exp_cur == NI - 1) ? (WRAP ? 0 : NI - 1) : exp_cur + 1;
    else    nxt = (exp_cur == 0)      ? (WRAP ? NI - 1 : 0) : exp_cur - 1;
    if (nxt != exp_cur) begin
      q_chg_cyc.push_back(at);
      q_chg_val.push_back(nxt);
    end
    exp_cur = nxt;
  endtask

  task automatic tap(input logic [3:0] b);
    int ev;
    ev = cyc + 1;
    if (b[0] ^ b[1]) step_exp(ev, b[1]);
    if (b[3]) q_back.push_back(ev);
    else if (b[2]) q_sel.push_back(ev);
    nav.btn_down  = b;
    nav.btn_state = b;
    tick(1);
    nav.btn_down  = 4'b0000;
    nav.btn_state = 4'b0000;
    tick(3);
  endtask

  task automatic hold_dir(input bit dn, input int n);
    logic [3:0] b;
    int ev;
    b  = dn ? 4'b0010 : 4'b0001;
    ev = cyc + 1;
    step_exp(ev, dn);
    for (int t = ev + DLY; t < ev + n; t += RPT) step_exp(t, dn);
    nav.btn_down  = b;
    nav.btn_state = b;
    tick(1);
    nav.btn_down  = 4'b0000;
    tick(n - 1);
    nav.btn_state = 4'b0000;
  endtask

  task automatic end_check(input string tag);
    check_eq({tag, "_chg_pend"},  q_chg_cyc.size(), 0);
    check_eq({tag, "_sel_pend"},  q_sel.size(), 0);
    check_eq({tag, "_back_pend"}, q_back.size(), 0);
    check_eq({tag, "_cursor"},    nav.cursor, exp_cur);
  endtask

  task automatic do_reset();
    check_eq("rst_pend", q_chg_cyc.size() + q_sel.size() + q_back.size(), 0);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_cursor", nav.cursor, 0);
    check_eq("rst_chg",    nav.cursor_chg, 0);
    check_eq("rst_sel",    nav.sel_pulse, 0);
    check_eq("rst_back",   nav.back_pulse, 0);
    exp_cur = 0;
    tick(2);
    resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (nav.cursor_chg) begin
        if (q_chg_cyc.size() == 0) check_eq("chg_unexpected", 1, 0);
        else begin
          mon_c = q_chg_cyc.pop_front();
          mon_v = q_chg_val.pop_front();
          check_eq("chg_cycle", cyc, mon_c);
          check_eq("chg_value", nav.cursor, mon_v);
        end
      end
      if (nav.sel_pulse) begin
        if (q_sel.size() == 0) check_eq("sel_unexpected", 1, 0);
        else check_eq("sel_cycle", cyc, q_sel.pop_front());
      end
      if (nav.back_pulse) begin
        if (q_back.size() == 0) check_eq("back_unexpected", 1, 0);
        else check_eq("back_cycle", cyc, q_back.pop_front());
      end
    end
  end

  initial begin
    nav.btn_down  = 4'b0000;
    nav.btn_state = 4'b0000;
    resetn        = 1'b0;
    tick(1);
    do_reset();

    // single down press, released next cycle
    tap(4'b0010);
    tick(12);
    end_check("t1");

    // up press at cursor 0 on the first cycle after reset release
    do_reset();
    tap(4'b0001);
    tick(12);
    end_check("t2");

    // down held 30 cycles from cursor 0
    do_reset();
    hold_dir(1'b1, 30);
    tick(16);
    end_check("t3");

    // simultaneous up+down, then back+select, select alone, back alone
    tap(4'b0011);
    tap(4'b1100);
    tap(4'b0100);
    tap(4'b1000);
    tick(2);
    end_check("t4");

    // up held into auto-repeat from cursor 4, select mid-hold, then down level raised
    do_reset();
    repeat (4) tap(4'b0010);
    e = cyc + 1;
    step_exp(e, 1'b0);
    step_exp(e + DLY, 1'b0);
    step_exp(e + DLY + RPT, 1'b0);
    nav.btn_down  = 4'b0001;
    nav.btn_state = 4'b0001;
    tick(1);
    nav.btn_down  = 4'b0000;
    tick(4);
    q_sel.push_back(cyc + 1);
    nav.btn_down  = 4'b0100;
    tick(1);
    nav.btn_down  = 4'b0000;
    tick(10);
    nav.btn_state = 4'b0011;
    tick(20);
    nav.btn_state = 4'b0000;
    tick(4);
    end_check("t5");

    // reset during auto-repeat at cursor 3 with the button still held afterwards
    e = cyc + 1;
    step_exp(e, 1'b1);
    step_exp(e + DLY, 1'b1);
    nav.btn_down  = 4'b0010;
    nav.btn_state = 4'b0010;
    tick(1);
    nav.btn_down  = 4'b0000;
    tick(12);
    check_eq("t6_cursor_before_rst", nav.cursor, 3);
    do_reset();
    tick(20);
    nav.btn_state = 4'b0000;
    tick(2);
    end_check("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
